cpc_romsel_ctrl: RTL and testbench

//  Upstream ROM-select stage of the CPC expansion ROM board, for the CPLD build. Decodes Z80
//  IO writes to the upper-ROM select port (&DFxx, A13 low) into a registered ROM number.

---
 rtl/cpc_romsel_pkg.sv | 28 ++
 rtl/cpc_romsel_ctrl_if.sv | 29 ++
 rtl/cpc_romsel_unlock.sv | 135 +++++++++++++
 rtl/cpc_romsel_ctrl.sv | 104 ++++++++++
 tb/tb_cpc_romsel_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpc_romsel_pkg.sv
// Shared types and constants for the CPC expansion ROM select stage.
//  - unlock_state_e : states of the EEPROM write-enable unlock sequencer
//  - KEY1 / KEY2    : unlock key bytes written to the unlock port
//  - SEL_PORT_A13   : A13 level that selects the upper-ROM select port
//  - slot_valid()   : slot number is inside the board and populated
package cpc_romsel_pkg;

  typedef enum logic [2:0] {
    LOCKED = 3'd0,
    K1     = 3'd1,
    K2     = 3'd2,
    ARMED  = 3'd3,
    PULSE  = 3'd4
  } unlock_state_e;

  localparam logic [7:0] KEY1         = 8'h55;
  localparam logic [7:0] KEY2         = 8'hAA;
  localparam logic       SEL_PORT_A13 = 1'b0;

  // en_ext is the slot enable vector zero-extended to 256 bits so any
  // 8-bit slot number can index it safely.
  function automatic logic slot_valid(input logic [7:0]   idx,
                                      input logic [255:0] en_ext,
                                      input logic [8:0]   nslots);
    return ({1'b0, idx} < nslots) & en_ext[idx];
  endfunction

endpackage

// File: rtl/cpc_romsel_ctrl_if.sv
// Z80-side bus bundle of the ROM select stage.
//  Inputs to the board : A, D, IOREQ_B, MREQ_B, WR_B, ROMEN_B, slot_en
//  Outputs of the board: cs_b, ROMDIS, rom_we_b, armed
//  master = bus/test driver, slave = cpc_romsel_ctrl.
interface cpc_romsel_ctrl_if #(
  parameter int NSLOTS = 8
);
  logic [15:0]       A;
  logic [7:0]        D;
  logic              IOREQ_B;
  logic              MREQ_B;
  logic              WR_B;
  logic              ROMEN_B;
  logic [NSLOTS-1:0] slot_en;
  logic [NSLOTS-1:0] cs_b;
  logic              ROMDIS;
  logic              rom_we_b;
  logic              armed;

  modport master (
    output A, D, IOREQ_B, MREQ_B, WR_B, ROMEN_B, slot_en,
    input  cs_b, ROMDIS, rom_we_b, armed
  );

  modport slave (
    input  A, D, IOREQ_B, MREQ_B, WR_B, ROMEN_B, slot_en,
    output cs_b, ROMDIS, rom_we_b, armed
  );
endinterface

// File: rtl/cpc_romsel_unlock.sv
// Guarded EEPROM write-enable sequencer.
//  Key sequence 55, AA, <slot> on the unlock port arms one write to <slot>.
//  An armed sequence expires after TIMEOUT cycles; the first matching
//  upper-ROM memory write produces a WE_PULSE-cycle low pulse on rom_we_b.
// Ports:
//  CLK, RESET_B : clock, async active-low reset
//  unlock_wr    : one-cycle strobe, IO write to the unlock port
//  data         : Z80 data bus
//  slot_en_ext  : slot enables zero-extended to 256 bits
//  mem_wr       : one-cycle strobe, memory write to &C000-&FFFF
//  idx          : currently selected ROM number relative to the board base
//  rom_we_b     : registered active-low EEPROM write enable
//  armed        : registered status, high in ARMED and PULSE
module cpc_romsel_unlock #(
  parameter int NSLOTS   = 8,
  parameter int TIMEOUT  = 4096,
  parameter int WE_PULSE = 3
) (
  input  logic         CLK,
  input  logic         RESET_B,
  input  logic         unlock_wr,
  input  logic [7:0]   data,
  input  logic [255:0] slot_en_ext,
  input  logic         mem_wr,
  input  logic [7:0]   idx,
  output logic         rom_we_b,
  output logic         armed
);
  import cpc_romsel_pkg::*;

  localparam int TW = $clog2(TIMEOUT);
  localparam int PW = $clog2(WE_PULSE + 1);
  localparam int CW = (TW > PW) ? TW : PW;
  localparam logic [CW-1:0] T_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] P_LAST   = CW'(WE_PULSE - 1);
  localparam logic [8:0]    NSLOTS_W = 9'(NSLOTS);

  unlock_state_e state_r, state_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic [7:0]    slot_r, slot_next_s;
  logic          rom_we_b_r;
  logic          armed_r;

  // Next-state logic; one counter serves as arm timer and pulse width counter.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    slot_next_s  = slot_r;
    case (state_r)
      LOCKED: begin
        if (unlock_wr && (data == KEY1)) begin
          state_next_s = K1;
        end else begin
          state_next_s = LOCKED;
        end
      end
      K1: begin
        if (unlock_wr) begin
          if (data == KEY2) begin
            state_next_s = K2;
          end else if (data == KEY1) begin
            state_next_s = K1;
          end else begin
            state_next_s = LOCKED;
          end
        end else begin
          state_next_s = K1;
        end
      end
      K2: begin
        if (unlock_wr) begin
          if (slot_valid(data, slot_en_ext, NSLOTS_W)) begin
            state_next_s = ARMED;
            slot_next_s  = data;
            cnt_next_s   = '0;
          end else if (data == KEY1) begin
            state_next_s = K1;
          end else begin
            state_next_s = LOCKED;
          end
        end else begin
          state_next_s = K2;
        end
      end
      ARMED: begin
        if (unlock_wr) begin
          state_next_s = LOCKED;
          cnt_next_s   = '0;
        end else if (mem_wr && (idx == slot_r)) begin
          state_next_s = PULSE;
          cnt_next_s   = '0;
        end else if (cnt_r == T_LAST) begin
          state_next_s = LOCKED;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s   = cnt_r + CW'(1'b1);
        end
      end
      PULSE: begin
        if (cnt_r == P_LAST) begin
          state_next_s = LOCKED;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s   = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        state_next_s = LOCKED;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; outputs are decoded from next state
  // so rom_we_b falls on the clock that captures the memory write.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_r    <= LOCKED;
      cnt_r      <= '0;
      slot_r     <= 8'h00;
      rom_we_b_r <= 1'b1;
      armed_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      slot_r     <= slot_next_s;
      rom_we_b_r <= (state_next_s != PULSE);
      armed_r    <= (state_next_s == ARMED) || (state_next_s == PULSE);
    end
  end

  assign rom_we_b = rom_we_b_r;
  assign armed    = armed_r;

endmodule

// File: rtl/cpc_romsel_ctrl.sv
// Upper-ROM select stage of the CPC expansion ROM board.
//  Latches the ROM number written to the select port (&DFxx, A13 low),
//  decodes active-low chip selects and ROMDIS for slots in this board's
//  window, and hosts the guarded EEPROM write-enable sequencer.
// Ports:
//  CLK     : Z80 clock, all state on rising edge
//  RESET_B : async active-low reset
//  bus     : cpc_romsel_ctrl_if.slave (Z80 bus, slot enables, board outputs)
module cpc_romsel_ctrl #(
  parameter int         NSLOTS    = 8,
  parameter logic [7:0] BASE_ROM  = 8'h00,
  parameter logic [7:0] UNLOCK_HI = 8'hDC,
  parameter int         TIMEOUT   = 4096,
  parameter int         WE_PULSE  = 3
) (
  input logic               CLK,
  input logic               RESET_B,
  cpc_romsel_ctrl_if.slave  bus
);
  import cpc_romsel_pkg::*;

  localparam logic [8:0] NSLOTS_W = 9'(NSLOTS);

  logic [7:0]        romsel_r;
  logic              io_wr_q_r;
  logic              mem_wr_q_r;
  logic              io_wr_s, mem_wr_s, io_edge_s, mem_edge_s;
  logic              unlock_port_s, unlock_wr_s, sel_wr_s, mem_hit_wr_s;
  logic [7:0]        idx_s;
  logic [255:0]      en_ext_s;
  logic              hit_s, rd_sel_s;
  logic [NSLOTS-1:0] cs_b_s;
  logic              unused_a_s;

  assign io_wr_s    = ~bus.IOREQ_B & ~bus.WR_B;
  assign mem_wr_s   = ~bus.MREQ_B & ~bus.WR_B;
  assign io_edge_s  = io_wr_s & ~io_wr_q_r;
  // IO decode wins should both strobes ever appear together.
  assign mem_edge_s = mem_wr_s & ~mem_wr_q_r & ~io_edge_s;

  // The unlock port is matched on the full high byte and is carved out of
  // the A13-low select range, so a key write never changes romsel.
  assign unlock_port_s = (bus.A[15:8] == UNLOCK_HI);
  assign unlock_wr_s   = io_edge_s & unlock_port_s;
  assign sel_wr_s      = io_edge_s & (bus.A[13] == SEL_PORT_A13) & ~unlock_port_s;
  assign mem_hit_wr_s  = mem_edge_s & (bus.A[15:14] == 2'b11);

  // Relative index wraps modulo 256, so ROM numbers below the base miss.
  assign idx_s    = romsel_r - BASE_ROM;
  assign en_ext_s = 256'(bus.slot_en);
  assign hit_s    = slot_valid(idx_s, en_ext_s, NSLOTS_W);
  assign rd_sel_s = hit_s & ~bus.ROMEN_B & bus.A[14];

  assign unused_a_s = ^bus.A[12:0];

  // One-hot active-low chip select for the selected slot during upper-ROM reads.
  always_comb begin
    cs_b_s = '1;
    for (int i = 0; i < NSLOTS; i++) begin
      if (rd_sel_s && (idx_s == 8'(i))) begin
        cs_b_s[i] = 1'b0;
      end else begin
        cs_b_s[i] = 1'b1;
      end
    end
  end

  // ROM number register and write-strobe edge detectors.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      romsel_r   <= 8'h00;
      io_wr_q_r  <= 1'b0;
      mem_wr_q_r <= 1'b0;
    end else begin
      io_wr_q_r  <= io_wr_s;
      mem_wr_q_r <= mem_wr_s;
      if (sel_wr_s) begin
        romsel_r <= bus.D;
      end else begin
        romsel_r <= romsel_r;
      end
    end
  end

  assign bus.cs_b   = cs_b_s;
  assign bus.ROMDIS = rd_sel_s;

  cpc_romsel_unlock #(
    .NSLOTS   (NSLOTS),
    .TIMEOUT  (TIMEOUT),
    .WE_PULSE (WE_PULSE)
  ) u_unlock (
    .CLK         (CLK),
    .RESET_B     (RESET_B),
    .unlock_wr   (unlock_wr_s),
    .data        (bus.D),
    .slot_en_ext (en_ext_s),
    .mem_wr      (mem_hit_wr_s),
    .idx         (idx_s),
    .rom_we_b    (bus.rom_we_b),
    .armed       (bus.armed)
  );

endmodule

// File: tb/tb_cpc_romsel_ctrl.sv
// Bench for cpc_romsel_ctrl: one instance at BASE_ROM=0, one at BASE_ROM=8,
// sharing the same bus stimulus. Expectations come from a ROM-number /
// key-progress model of the board's behaviour.
module tb_cpc_romsel_ctrl;

  localparam int TIMEOUT = 4096;

  int errors = 0;
  int checks = 0;

  logic       CLK = 1'b0;
  logic       RESET_B = 1'b0;
  logic [7:0] m_en = 8'hFF;

  // model state
  logic [7:0] m_romsel = 8'h00;
  int         m_prog = 0;   // 0 locked, 1 got 55, 2 got 55 AA, 3 armed
  int         m_slot = 0;

  always #5 CLK = ~CLK;

  cpc_romsel_ctrl_if #(.NSLOTS(8)) bus0 ();
  cpc_romsel_ctrl_if #(.NSLOTS(8)) bus8 ();

  assign bus0.slot_en = m_en;
  assign bus8.A       = bus0.A;
  assign bus8.D       = bus0.D;
  assign bus8.IOREQ_B = bus0.IOREQ_B;
  assign bus8.MREQ_B  = bus0.MREQ_B;
  assign bus8.WR_B    = bus0.WR_B;
  assign bus8.ROMEN_B = bus0.ROMEN_B;
  assign bus8.slot_en = m_en;

  cpc_romsel_ctrl #(.NSLOTS(8), .BASE_ROM(8'h00), .UNLOCK_HI(8'hDC),
                    .TIMEOUT(TIMEOUT), .WE_PULSE(3))
    dut0 (.CLK(CLK), .RESET_B(RESET_B), .bus(bus0));

  cpc_romsel_ctrl #(.NSLOTS(8), .BASE_ROM(8'h08), .UNLOCK_HI(8'hDC),
                    .TIMEOUT(TIMEOUT), .WE_PULSE(3))
    dut8 (.CLK(CLK), .RESET_B(RESET_B), .bus(bus8));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // {ROMDIS, cs_b} expected for a board whose window starts at base.
  function automatic logic [8:0] exp_decode(input int base, input logic [7:0] rs,
                                            input logic [7:0] en, input logic [15:0] a,
                                            input logic romen_b);
    int idx;
    logic rd;
    logic [7:0] cs;
    idx = (int'(rs) - base + 256) % 256;
    rd  = (idx < 8) && en[idx % 8] && !romen_b && a[14];
    cs  = 8'hFF;
    if (rd) cs[idx % 8] = 1'b0;
    return {rd, cs};
  endfunction

  task automatic unlock_step(input logic [7:0] b);
    if (m_prog == 3) m_prog = 0;
    else if (m_prog == 2 && b < 8'd8 && m_en[b[2:0]]) begin m_prog = 3; m_slot = int'(b); end
    else if (b == 8'h55) m_prog = 1;
    else if (m_prog == 1 && b == 8'hAA) m_prog = 2;
    else m_prog = 0;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus0.A = a; bus0.D = d; bus0.IOREQ_B = 1'b0; bus0.WR_B = 1'b0;
    @(negedge CLK);
    bus0.IOREQ_B = 1'b1; bus0.WR_B = 1'b1;
    @(negedge CLK);
    if (a[15:8] == 8'hDC) unlock_step(d);
    else if (!a[13]) m_romsel = d;
  endtask

  task automatic drive_read(input logic [15:0] a, input logic romen_b);
    @(negedge CLK);
    bus0.A = a; bus0.ROMEN_B = romen_b;
    #1;
  endtask

  // Memory write; samples rom_we_b/armed of dut0 on 8 consecutive negedges,
  // sample 0 taken in the cycle the strobe is first driven.
  task automatic mem_write(input logic [15:0] a, output logic [7:0] we_lo, output logic [7:0] arm_obs);
    @(negedge CLK);
    bus0.A = a; bus0.MREQ_B = 1'b0; bus0.WR_B = 1'b0;
    #1;
    we_lo[0] = ~bus0.rom_we_b; arm_obs[0] = bus0.armed;
    for (int k = 1; k < 8; k++) begin
      @(negedge CLK);
      we_lo[k] = ~bus0.rom_we_b; arm_obs[k] = bus0.armed;
      if (k == 1) begin bus0.MREQ_B = 1'b1; bus0.WR_B = 1'b1; end
    end
  endtask

  // Expected 8-sample pattern of a memory write, and model update.
  task automatic exp_mem(input logic [15:0] a, output logic [7:0] we_lo, output logic [7:0] arm_obs);
    logic pulse;
    pulse = (m_prog == 3) && (a[15:14] == 2'b11) && (int'(m_romsel) == m_slot);
    if (pulse) begin
      we_lo = 8'b0000_1110; arm_obs = 8'b0000_1111; m_prog = 0;
    end else begin
      we_lo = 8'h00; arm_obs = (m_prog == 3) ? 8'hFF : 8'h00;
    end
  endtask

  task automatic test_reset;
    logic [8:0] e0, e8;
    bus0.A = 16'h0000; bus0.D = 8'h00; bus0.IOREQ_B = 1'b1; bus0.MREQ_B = 1'b1;
    bus0.WR_B = 1'b1; bus0.ROMEN_B = 1'b1; RESET_B = 1'b0;
    @(negedge CLK); @(negedge CLK);
    checks++;
    if (bus0.rom_we_b !== 1'b1 || bus0.armed !== 1'b0) begin
      errors++; $display("FAIL reset_out: rom_we_b/armed=%b/%b expected 1/0", bus0.rom_we_b, bus0.armed);
    end
    RESET_B = 1'b1;
    m_romsel = 8'h00; m_prog = 0;
    drive_read(16'hC000, 1'b0);
    e0 = exp_decode(0, m_romsel, m_en, 16'hC000, 1'b0);
    e8 = exp_decode(8, m_romsel, m_en, 16'hC000, 1'b0);
    checks++;
    if ({bus0.ROMDIS, bus0.cs_b} !== e0) begin
      errors++; $display("FAIL reset_dec0: got %h expected %h", {bus0.ROMDIS, bus0.cs_b}, e0);
    end
    checks++;
    if ({bus8.ROMDIS, bus8.cs_b} !== e8) begin
      errors++; $display("FAIL reset_dec8: got %h expected %h", {bus8.ROMDIS, bus8.cs_b}, e8);
    end
  endtask

  task automatic test_select;
    logic [15:0] wa [6] = '{16'hDF00, 16'hDF00, 16'hDF00, 16'hDF00, 16'hFF00, 16'h1F42};
    logic [7:0]  wd [6] = '{8'h05, 8'h09, 8'h05, 8'h05, 8'h02, 8'h02};
    logic [7:0]  we [6] = '{8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'hFF, 8'hFF};
    logic [15:0] ra [6] = '{16'hC000, 16'hC000, 16'hC000, 16'h8000, 16'hC000, 16'hE000};
    logic        rr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [8:0]  e0;
    for (int i = 0; i < 6; i++) begin
      m_en = we[i];
      io_write(wa[i], wd[i]);
      drive_read(ra[i], rr[i]);
      e0 = exp_decode(0, m_romsel, m_en, ra[i], rr[i]);
      checks++;
      if ({bus0.ROMDIS, bus0.cs_b} !== e0) begin
        errors++; $display("FAIL select_%0d: got %h expected %h", i, {bus0.ROMDIS, bus0.cs_b}, e0);
      end
    end
    // ROMEN_B high: ROMDIS drops with it
    drive_read(16'hC000, 1'b1);
    checks++;
    if ({bus0.ROMDIS, bus0.cs_b} !== 9'h0FF) begin
      errors++; $display("FAIL romen_high: got %h expected 0ff", {bus0.ROMDIS, bus0.cs_b});
    end
    m_en = 8'hFF;
  endtask

  task automatic test_base8;
    logic [7:0] rs [3] = '{8'h07, 8'h0F, 8'h0A};
    logic [8:0] e0, e8;
    for (int i = 0; i < 3; i++) begin
      io_write(16'hDF00, rs[i]);
      drive_read(16'hC000, 1'b0);
      e0 = exp_decode(0, m_romsel, m_en, 16'hC000, 1'b0);
      e8 = exp_decode(8, m_romsel, m_en, 16'hC000, 1'b0);
      checks++;
      if ({bus8.ROMDIS, bus8.cs_b} !== e8) begin
        errors++; $display("FAIL base8_%0d: got %h expected %h", i, {bus8.ROMDIS, bus8.cs_b}, e8);
      end
      checks++;
      if ({bus0.ROMDIS, bus0.cs_b} !== e0) begin
        errors++; $display("FAIL base0_%0d: got %h expected %h", i, {bus0.ROMDIS, bus0.cs_b}, e0);
      end
    end
  endtask

  task automatic test_program;
    logic [7:0] we_lo, arm_obs, e_we, e_arm;
    io_write(16'hDC00, 8'h55); io_write(16'hDC00, 8'hAA); io_write(16'hDC00, 8'h03);
    io_write(16'hDF00, 8'h03);
    checks++;
    if (bus0.armed !== 1'b1) begin
      errors++; $display("FAIL prog_armed: got %b expected 1", bus0.armed);
    end
    exp_mem(16'hC123, e_we, e_arm);
    mem_write(16'hC123, we_lo, arm_obs);
    checks++;
    if (we_lo !== e_we || e_we !== 8'b0000_1110) begin
      errors++; $display("FAIL prog_pulse: we_lo=%b expected %b", we_lo, e_we);
    end
    checks++;
    if (arm_obs !== e_arm) begin
      errors++; $display("FAIL prog_arm: armed=%b expected %b", arm_obs, e_arm);
    end
    // only one write per arm sequence
    exp_mem(16'hC123, e_we, e_arm);
    mem_write(16'hC123, we_lo, arm_obs);
    checks++;
    if (we_lo !== 8'h00 || arm_obs !== e_arm) begin
      errors++; $display("FAIL prog_second: we_lo/armed=%b/%b expected 00000000/%b", we_lo, arm_obs, e_arm);
    end
  endtask

  task automatic test_bad_seq;
    logic [7:0] seqs [4][4] = '{'{8'h55, 8'hAA, 8'h09, 8'h00}, '{8'h55, 8'h12, 8'h00, 8'h00},
                                '{8'h55, 8'h55, 8'hAA, 8'h03}, '{8'h77, 8'h00, 8'h00, 8'h00}};
    int          lens [4] = '{3, 2, 4, 1};
    logic [7:0] we_lo, arm_obs, e_we, e_arm;
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < lens[s]; j++) io_write(16'hDC00, seqs[s][j]);
      checks++;
      if (bus0.armed !== (m_prog == 3)) begin
        errors++; $display("FAIL seq_%0d_armed: got %b expected %b", s, bus0.armed, (m_prog == 3));
      end
      if (s == 2) begin
        // wrong slot selected: no pulse, stays armed
        io_write(16'hDF00, 8'h04);
        exp_mem(16'hC000, e_we, e_arm);
        mem_write(16'hC000, we_lo, arm_obs);
        checks++;
        if (we_lo !== e_we || arm_obs !== e_arm) begin
          errors++; $display("FAIL wrong_slot: we_lo/armed=%b/%b expected %b/%b", we_lo, arm_obs, e_we, e_arm);
        end
      end
    end
    io_write(16'hDF00, 8'h03);
    exp_mem(16'hC000, e_we, e_arm);
    mem_write(16'hC000, we_lo, arm_obs);
    checks++;
    if (we_lo !== 8'h00 || arm_obs !== e_arm) begin
      errors++; $display("FAIL bad_seq_nopulse: we_lo/armed=%b/%b expected 00000000/%b", we_lo, arm_obs, e_arm);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] we_lo, arm_obs, e_we, e_arm;
    io_write(16'hDF00, 8'h02);
    io_write(16'hDC00, 8'h55); io_write(16'hDC00, 8'hAA); io_write(16'hDC00, 8'h02);
    repeat (TIMEOUT - 2) @(negedge CLK);
    checks++;
    if (bus0.armed !== 1'b1) begin
      errors++; $display("FAIL timeout_last: armed=%b expected 1", bus0.armed);
    end
    @(negedge CLK);
    m_prog = 0;
    checks++;
    if (bus0.armed !== 1'b0) begin
      errors++; $display("FAIL timeout_expire: armed=%b expected 0", bus0.armed);
    end
    exp_mem(16'hC000, e_we, e_arm);
    mem_write(16'hC000, we_lo, arm_obs);
    checks++;
    if (we_lo !== e_we || arm_obs !== e_arm) begin
      errors++; $display("FAIL timeout_nopulse: we_lo/armed=%b/%b expected %b/%b", we_lo, arm_obs, e_we, e_arm);
    end
  endtask

  task automatic test_reset_pulse;
    logic [8:0] e0;
    io_write(16'hDC00, 8'h55); io_write(16'hDC00, 8'hAA); io_write(16'hDC00, 8'h03);
    io_write(16'hDF00, 8'h03);
    @(negedge CLK);
    bus0.A = 16'hC000; bus0.MREQ_B = 1'b0; bus0.WR_B = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus0.rom_we_b !== 1'b0) begin
      errors++; $display("FAIL pulse_start: rom_we_b=%b expected 0", bus0.rom_we_b);
    end
    #2 RESET_B = 1'b0;
    #1;
    checks++;
    if (bus0.rom_we_b !== 1'b1 || bus0.armed !== 1'b0) begin
      errors++; $display("FAIL reset_mid_pulse: rom_we_b/armed=%b/%b expected 1/0", bus0.rom_we_b, bus0.armed);
    end
    bus0.MREQ_B = 1'b1; bus0.WR_B = 1'b1;
    @(negedge CLK); @(negedge CLK);
    RESET_B = 1'b1;
    m_romsel = 8'h00; m_prog = 0;
    drive_read(16'hC000, 1'b0);
    e0 = exp_decode(0, m_romsel, m_en, 16'hC000, 1'b0);
    checks++;
    if ({bus0.ROMDIS, bus0.cs_b} !== e0) begin
      errors++; $display("FAIL reset_romsel: got %h expected %h", {bus0.ROMDIS, bus0.cs_b}, e0);
    end
  endtask

  // Random mix; short enough that an arm never reaches its timeout here.
  task automatic test_random;
    logic [7:0]  we_lo, arm_obs, e_we, e_arm, hi, b;
    logic [15:0] a;
    logic        rb;
    logic [8:0]  e0, e8;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0: begin
          hi = 8'($urandom_range(0, 255)) & 8'hDF;
          if (hi == 8'hDC) hi = 8'hDF;
          io_write({hi, 8'($urandom_range(0, 255))}, 8'($urandom_range(0, 17)));
        end
        1: io_write({8'($urandom_range(0, 255)) | 8'h20, 8'h00}, 8'($urandom_range(0, 255)));
        2: begin
          case ($urandom_range(0, 3))
            0: b = 8'h55;
            1: b = 8'hAA;
            2: b = 8'($urandom_range(0, 9));
            default: b = 8'($urandom_range(0, 255));
          endcase
          io_write(16'hDC00, b);
          checks++;
          if (bus0.armed !== (m_prog == 3)) begin
            errors++; $display("FAIL rnd_armed_%0d: got %b expected %b", n, bus0.armed, (m_prog == 3));
          end
        end
        3: begin
          a = 16'($urandom_range(0, 65535));
          if ($urandom_range(0, 1) == 1) a[15:14] = 2'b11;
          exp_mem(a, e_we, e_arm);
          mem_write(a, we_lo, arm_obs);
          checks++;
          if (we_lo !== e_we || arm_obs !== e_arm) begin
            errors++; $display("FAIL rnd_mem_%0d: we_lo/armed=%b/%b expected %b/%b", n, we_lo, arm_obs, e_we, e_arm);
          end
        end
        4: begin
          if ($urandom_range(0, 3) == 0) m_en = 8'($urandom_range(0, 255));
          else m_en = 8'hFF;
          a  = 16'($urandom_range(0, 65535));
          rb = 1'($urandom_range(0, 3) == 0);
          drive_read(a, rb);
          e0 = exp_decode(0, m_romsel, m_en, a, rb);
          e8 = exp_decode(8, m_romsel, m_en, a, rb);
          checks++;
          if ({bus0.ROMDIS, bus0.cs_b} !== e0 || {bus8.ROMDIS, bus8.cs_b} !== e8) begin
            errors++; $display("FAIL rnd_dec_%0d: got %h/%h expected %h/%h", n,
                               {bus0.ROMDIS, bus0.cs_b}, {bus8.ROMDIS, bus8.cs_b}, e0, e8);
          end
        end
        default: begin
          b = 8'($urandom_range(0, 9));
          io_write(16'hDC00, 8'h55); io_write(16'hDC00, 8'hAA); io_write(16'hDC00, b);
          if ($urandom_range(0, 1) == 1) io_write(16'hDF00, b);
          checks++;
          if (bus0.armed !== (m_prog == 3)) begin
            errors++; $display("FAIL rnd_arm_%0d: got %b expected %b", n, bus0.armed, (m_prog == 3));
          end
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_base8();
    test_program();
    test_bad_seq();
    test_timeout();
    test_reset_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
